// File: rtl/seq_cam_pkg.sv
// Shared constants and helpers for the sequential CAM.
package seq_cam_pkg;

    localparam int DEF_NUM_ENTRIES = 8;
    localparam int DEF_DATA_WIDTH  = 8;

    // Index width for an n-entry array; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_cam_if.sv
// Request/response bundle for the CAM. The master side drives updates and
// searches; the slave side (the CAM) returns search results and the valid count.
// Optional feature: SEQ_CAM_MASK_EN adds the per-bit search_mask.
interface seq_cam_if
    import seq_cam_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
    localparam int IW = idx_width(NUM_ENTRIES);

    logic                   write_en;
    logic [IW-1:0]          write_addr;
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   inv_en;
    logic [IW-1:0]          inv_addr;
    logic                   clear_all;
    logic                   search_en;
    logic [DATA_WIDTH-1:0]  search_data;
`ifdef SEQ_CAM_MASK_EN
    logic [DATA_WIDTH-1:0]  search_mask;
`endif
    logic                   resp_val;
    logic [NUM_ENTRIES-1:0] resp_match;
    logic                   resp_hit;
    logic [IW-1:0]          resp_idx;
    logic [IW:0]            num_valid;

    modport master (
        output write_en, write_addr, write_data, inv_en, inv_addr, clear_all,
               search_en, search_data,
`ifdef SEQ_CAM_MASK_EN
               search_mask,
`endif
        input  resp_val, resp_match, resp_hit, resp_idx, num_valid
    );

    modport slave (
        input  write_en, write_addr, write_data, inv_en, inv_addr, clear_all,
               search_en, search_data,
`ifdef SEQ_CAM_MASK_EN
               search_mask,
`endif
        output resp_val, resp_match, resp_hit, resp_idx, num_valid
    );

endinterface

// File: rtl/seq_cam_prio_enc.sv
// Lowest-index-wins priority encoder over the CAM match vector.
module seq_cam_prio_enc
    import seq_cam_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    localparam int IW         = idx_width(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] req,
    output logic                   hit,
    output logic [IW-1:0]          idx
);

    // Scan from the top down so the lowest set bit is the last one to land.
    always_comb begin
        idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

    assign hit = |req;

endmodule

// File: rtl/seq_cam_param.sv
// Sequential CAM: one-cycle registered search, write/invalidate/clear-all
// updates and a live valid-entry count. Searches see the state from before
// the same edge's updates.
// Optional feature: define SEQ_CAM_MASK_EN for a per-bit don't-care mask.
module seq_cam_param
    import seq_cam_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    seq_cam_if.slave  bus
);
    localparam int IW = idx_width(NUM_ENTRIES);
    localparam int CW = IW + 1;

    logic [DATA_WIDTH-1:0]  mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          num_valid_q;

    logic [DATA_WIDTH-1:0]  cmp_mask;
    logic [NUM_ENTRIES-1:0] match_d;
    logic                   hit_d;
    logic [IW-1:0]          idx_d;

    logic                   resp_val_q;
    logic [NUM_ENTRIES-1:0] resp_match_q;
    logic                   resp_hit_q;
    logic [IW-1:0]          resp_idx_q;

`ifdef SEQ_CAM_MASK_EN
    assign cmp_mask = bus.search_mask;
`else
    assign cmp_mask = '1;
`endif

    // Per-entry compare against current (pre-update) contents and valid bits.
    genvar g;
    generate
        for (g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
            assign match_d[g] = valid_q[g] &&
                                (((mem[g] ^ bus.search_data) & cmp_mask) == '0);
        end
    endgenerate

    seq_cam_prio_enc #(.NUM_ENTRIES(NUM_ENTRIES)) u_prio (
        .req (match_d),
        .hit (hit_d),
        .idx (idx_d)
    );

    // Next valid vector: clear_all dominates; write is applied after the
    // invalidate so it wins on a shared address.
    always_comb begin
        valid_d = valid_q;
        if (bus.inv_en)   valid_d[bus.inv_addr]   = 1'b0;
        if (bus.write_en) valid_d[bus.write_addr] = 1'b1;
        if (bus.clear_all) valid_d = '0;
    end

    // Population count of the next valid vector; cannot exceed NUM_ENTRIES.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cnt_d = cnt_d + CW'(valid_d[i]);
        end
    end

    // Entry data storage, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (bus.write_en) mem[bus.write_addr] <= bus.write_data;
    end

    // Valid bits, count and registered search response.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            num_valid_q  <= '0;
            resp_val_q   <= 1'b0;
            resp_match_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            num_valid_q  <= cnt_d;
            resp_val_q   <= bus.search_en;
            resp_match_q <= bus.search_en ? match_d : '0;
            resp_hit_q   <= bus.search_en & hit_d;
            resp_idx_q   <= bus.search_en ? idx_d : '0;
        end
    end

    assign bus.resp_val   = resp_val_q;
    assign bus.resp_match = resp_match_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_idx   = resp_idx_q;
    assign bus.num_valid  = num_valid_q;

endmodule

// File: tb/tb_seq_cam_param.sv
// Directed table-driven bench for seq_cam_param (8 entries x 8 bits).
module tb_seq_cam_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_cam_if #(.NUM_ENTRIES(8), .DATA_WIDTH(8)) bus ();

    seq_cam_param #(.NUM_ENTRIES(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       we;  logic [2:0] wa; logic [7:0] wd;
        logic       ie;  logic [2:0] ia;
        logic       clr;
        logic       se;  logic [7:0] sd; logic [7:0] sm;
        logic       ev;  logic [7:0] em; logic eh; logic [2:0] ei; logic [3:0] en;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [2:0] wa, input logic [7:0] wd,
        input logic ie, input logic [2:0] ia, input logic clr,
        input logic se, input logic [7:0] sd, input logic [7:0] sm,
        input logic ev, input logic [7:0] em, input logic eh,
        input logic [2:0] ei, input logic [3:0] en);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.clr = clr;
        v.se = se; v.sd = sd; v.sm = sm;
        v.ev = ev; v.em = em; v.eh = eh; v.ei = ei; v.en = en;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.write_en    = v.we;  bus.write_addr = v.wa; bus.write_data = v.wd;
        bus.inv_en      = v.ie;  bus.inv_addr   = v.ia;
        bus.clear_all   = v.clr;
        bus.search_en   = v.se;  bus.search_data = v.sd;
`ifdef SEQ_CAM_MASK_EN
        bus.search_mask = v.sm;
`endif
    endtask

    // Apply at the falling edge, check 1 time unit after the rising edge.
    task automatic step(input vec_t v, input int k);
        drive(v);
        @(posedge clk); #1;
        chk($sformatf("v%0d.resp_val", k),   int'(bus.resp_val),   int'(v.ev));
        chk($sformatf("v%0d.resp_match", k), int'(bus.resp_match), int'(v.em));
        chk($sformatf("v%0d.resp_hit", k),   int'(bus.resp_hit),   int'(v.eh));
        chk($sformatf("v%0d.resp_idx", k),   int'(bus.resp_idx),   int'(v.ei));
        chk($sformatf("v%0d.num_valid", k),  int'(bus.num_valid),  int'(v.en));
        @(negedge clk);
    endtask

    initial begin
        vec_t idle;
        int   fill_nv [8] = '{3, 4, 5, 5, 6, 6, 7, 8};
        idle = mk(0,0,0, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,0);

        //         we wa wd     ie ia clr se sd     sm      ev em     eh ei nv
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h00,8'hFF, 1,8'h00,0,0,0)); // empty search
        tbl.push_back(mk(1,2,8'h5A, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,1));
        tbl.push_back(mk(1,6,8'h5A, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,2));
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h5A,8'hFF, 1,8'h44,1,2,2)); // two hits
        tbl.push_back(mk(1,1,8'h33, 0,0, 0, 1,8'h33,8'hFF, 1,8'h00,0,0,3)); // same-cycle write unseen
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h33,8'hFF, 1,8'h02,1,1,3));
        tbl.push_back(mk(1,3,8'h77, 1,3, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,4)); // write beats inv
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h77,8'hFF, 1,8'h08,1,3,4));
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h5A,8'hFF, 1,8'h44,1,2,4)); // back-to-back
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h11,8'hFF, 1,8'h00,0,0,4));
        tbl.push_back(mk(1,0,8'h5A, 1,2, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,4)); // write+inv, diff addr
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h5A,8'hFF, 1,8'h41,1,0,4));
        tbl.push_back(mk(0,0,8'h00, 1,2, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,4)); // inv of invalid
        tbl.push_back(mk(1,6,8'h5A, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,4)); // rewrite valid
        tbl.push_back(mk(0,0,8'h00, 1,5, 0, 1,8'h5A,8'hFF, 1,8'h41,1,0,4));
        tbl.push_back(mk(1,4,8'hAA, 0,0, 1, 1,8'h5A,8'hFF, 1,8'h41,1,0,0)); // clear beats write
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'hAA,8'hFF, 1,8'h00,0,0,0)); // invalid never matches
        tbl.push_back(mk(1,3,8'h5B, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,1));
        tbl.push_back(mk(1,5,8'h5A, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,2));
`ifdef SEQ_CAM_MASK_EN
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h5A,8'hFE, 1,8'h28,1,3,2));
`else
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h5A,8'hFE, 1,8'h20,1,5,2));
`endif
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,3'(i),8'(8'h10 + i), 0,0, 0, 0,8'h00,8'hFF,
                             0,8'h00,0,0,4'(fill_nv[i])));
        tbl.push_back(mk(1,7,8'h17, 0,0, 0, 0,8'h00,8'hFF, 0,8'h00,0,0,8)); // no wrap
        tbl.push_back(mk(0,0,8'h00, 0,0, 0, 1,8'h17,8'hFF, 1,8'h80,1,7,8));

        // Reset with a search pending: result must be discarded.
        reset = 1'b1;
        drive(idle);
        bus.search_en = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst.resp_val",   int'(bus.resp_val),   0);
        chk("rst.resp_match", int'(bus.resp_match), 0);
        chk("rst.resp_hit",   int'(bus.resp_hit),   0);
        chk("rst.resp_idx",   int'(bus.resp_idx),   0);
        chk("rst.num_valid",  int'(bus.num_valid),  0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) step(tbl[k], k);

        // Mid-run reset with a search: discarded, valid bits cleared.
        reset = 1'b1;
        drive(mk(0,0,8'h00, 0,0, 0, 1,8'h17,8'hFF, 0,8'h00,0,0,0));
        @(posedge clk); #1;
        chk("rst2.resp_val",  int'(bus.resp_val),  0);
        chk("rst2.num_valid", int'(bus.num_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0,0,8'h00, 0,0, 0, 1,8'h17,8'hFF, 1,8'h00,0,0,0), 100);
        step(idle, 101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_cam_param.md
SEQ_CAM_PARAM -- requirements
Module: seq_cam_param

Interface
- REQ-001: NUM_ENTRIES, default 8, number of CAM entries; SHALL be a power of two and at least 2.
- REQ-002: DATA_WIDTH, default 8, width in bits of each entry and of the search key.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: write_en  input  1  writes write_data to entry write_addr and sets that entry's valid bit.
- REQ-006: write_addr  input  clog2(NUM_ENTRIES)  target entry of the write.
- REQ-007: write_data  input  DATA_WIDTH  data to store.
- REQ-008: inv_en  input  1  clears the valid bit of entry inv_addr.
- REQ-009: inv_addr  input  clog2(NUM_ENTRIES)  target entry of the invalidate.
- REQ-010: clear_all  input  1  clears every valid bit.
- REQ-011: search_en  input  1  launches a search this cycle.
- REQ-012: search_data  input  DATA_WIDTH  search key.
- REQ-013: resp_val  output  1  search result is valid this cycle.
- REQ-014: resp_match  output  NUM_ENTRIES  bit i set when entry i is valid and equal to the key.
- REQ-015: resp_hit  output  1  OR-reduction of resp_match.
- REQ-016: resp_idx  output  clog2(NUM_ENTRIES)  lowest set index in resp_match; 0 when resp_hit is 0.
- REQ-017: num_valid  output  clog2(NUM_ENTRIES)+1  count of valid entries.

Function
- REQ-018: Search latency SHALL be exactly one cycle: a search_en at edge N SHALL produce resp_val=1 and its results during cycle N+1.
- REQ-019: resp_val SHALL be 0 in any cycle not following a search_en; resp_match, resp_hit and resp_idx SHALL be all-zero whenever resp_val=0.
- REQ-020: The search SHALL compare against contents and valid bits as they stood before the same edge's write, invalidate or clear, so a same-cycle update is not visible to that search.
- REQ-021: Invalid entries SHALL never match, whatever their stored data.
- REQ-022: Update priority at each edge SHALL be: clear_all over write and invalidate; write over invalidate on the same address; a write and an invalidate on different addresses SHALL both take effect.
- REQ-023: num_valid SHALL equal the population count of the valid bits after each edge: +1 for a write to an invalid entry, unchanged for a write to a valid entry, -1 for an invalidate of a valid entry, 0 after clear_all.
- REQ-024: num_valid SHALL saturate naturally at NUM_ENTRIES and SHALL NOT wrap; an invalidate of an invalid entry SHALL leave it unchanged.
- REQ-025: A search issued every cycle SHALL be fully pipelined, giving one result per cycle with no stalls.

Reset
- REQ-026: While reset is high: all valid bits SHALL be 0, num_valid SHALL be 0, and resp_val, resp_match, resp_hit and resp_idx SHALL be 0.
- REQ-027: Entry data storage SHALL NOT be reset.
- REQ-028: A search launched in the cycle reset is asserted SHALL be discarded, giving resp_val=0 in the next cycle.

Configuration
- REQ-029: With SEQ_CAM_MASK_EN defined, an extra input search_mask (DATA_WIDTH) SHALL exist; bits at 0 are don't-care in the comparison.
- REQ-030: Without SEQ_CAM_MASK_EN, the search_mask port SHALL be absent and the comparison SHALL be exact on all DATA_WIDTH bits.

Structure
- REQ-031: A shared package seq_cam_pkg SHALL hold the default NUM_ENTRIES and DATA_WIDTH constants and a function returning the index width.
- REQ-032: The lowest-index selection SHALL be a separate sub-module seq_cam_prio_enc, parametrised by NUM_ENTRIES, with outputs hit and idx.

Verification
- REQ-033: Reset, then search 0x00 -> resp_val=1, resp_match=0, resp_hit=0, num_valid=0.
- REQ-034: Write 0x5A to entries 2 and 6, then search 0x5A -> resp_match=0x44, resp_hit=1, resp_idx=2, num_valid=2.
- REQ-035: Write 0x33 to entry 1 in the same cycle as a search for 0x33 -> the result has resp_hit=0; repeating the search next cycle -> resp_match=0x02.
- REQ-036: Write entry 3 and invalidate entry 3 in the same cycle -> entry 3 valid and num_valid incremented; clear_all together with a write -> num_valid=0.
- REQ-037: Back-to-back searches for 0x5A then 0x11 on consecutive cycles -> consecutive results 0x44 then 0x00, with resp_val high on both cycles.
- REQ-038: With SEQ_CAM_MASK_EN: entries 0x5A and 0x5B, search 0x5A with mask 0xFE -> both entries match and resp_idx is the lower of the two.
